// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Defaults match the legacy fixed-pattern detector: 4-bit pattern 1011 and
// an 8-bit match counter.
package seq_det_pkg;

  localparam int         SEQ_DET_PAT_W       = 4;
  localparam logic [3:0] SEQ_DET_DEFAULT_PAT = 4'b1011;
  localparam int         SEQ_DET_CNT_W       = 8;

  // Number of bits needed to encode values 0 .. value-1.
  // The fill counter is sized with clog2(PAT_W+1) so that it can hold PAT_W.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// clr has priority over inc; once the count reaches all-ones it holds there
// until cleared or reset.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic at_max;

  // Saturation flag kept separate so the register process stays trivial.
  always_comb begin
    at_max = (count == CNT_MAX);
  end

  // Count register: clear wins over increment, increment stops at the maximum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
//
// A PAT_W-bit history register shifts in sequence_in on every clock edge
// where in_valid is high. A fill counter tracks how many fresh bits the
// history holds since the last restart (reset, pattern_load, or a
// non-overlapping match); a match needs a full history that equals the
// loaded pattern. detector_out is a registered one-cycle pulse, and
// match_count is a saturating count of matches.
//
// Input qualifier: sequence_in is consumed only on a rising clock edge
// where in_valid=1 and pattern_load=0; there is no back-pressure, so every
// qualified bit is accepted on that edge and never held for a later one.
//
// Optional feature, macro SEQ_DET_MASK_EN: adds a pattern_mask input that is
// latched with pattern_load (reset value all-ones). A 0 bit in the latched
// mask makes that pattern position a don't-care. Without the macro the
// compare is exact and no mask port or mask register exists.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = SEQ_DET_PAT_W,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DET_DEFAULT_PAT),
  parameter int               CNT_W       = SEQ_DET_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pattern_mask,
`endif
  input  logic             pattern_load,
  input  logic             overlap_en,
  input  logic             count_clear,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W   = clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  // Detection state.
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  pat_reg;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]  mask_reg;
`endif

  // Values the state would take if the current bit were shifted in.
  logic [PAT_W-1:0]  new_hist;
  logic [FILL_W-1:0] new_fill;
  logic              pattern_hit;
  logic              shift_en;
  logic              match;

  // Shifted-in candidate history and saturating fill count.
  always_comb begin
    new_hist = {hist[PAT_W-2:0], sequence_in};
    if (fill == FILL_FULL) begin
      new_fill = fill;
    end else begin
      new_fill = fill + FILL_W'(1);
    end
  end

  // Pattern compare on the candidate history (masked when the feature is built in).
  always_comb begin
`ifdef SEQ_DET_MASK_EN
    pattern_hit = (((new_hist ^ pat_reg) & mask_reg) == '0);
`else
    pattern_hit = (new_hist == pat_reg);
`endif
  end

  // A bit is consumed only when valid and not overridden by a pattern load;
  // a match additionally needs PAT_W fresh bits in the history.
  always_comb begin
    shift_en = in_valid && !pattern_load;
    match    = shift_en && (new_fill == FILL_FULL) && pattern_hit;
  end

  // Pattern (and mask) register: reloaded only by pattern_load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_reg <= DEFAULT_PAT;
`ifdef SEQ_DET_MASK_EN
      mask_reg <= '1;
`endif
    end else if (pattern_load) begin
      pat_reg <= pattern;
`ifdef SEQ_DET_MASK_EN
      mask_reg <= pattern_mask;
`endif
    end
  end

  // History and fill: a load restarts detection, a non-overlapping match
  // empties fill so the next match needs PAT_W fresh bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (pattern_load) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= new_hist;
      if (match && !overlap_en) begin
        fill <= '0;
      end else begin
        fill <= new_fill;
      end
    end
  end

  // Registered one-cycle match pulse; drops whenever no match is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      detector_out <= 1'b0;
    end else begin
      detector_out <= match;
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (count_clear),
    .count (match_count)
  );

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector; successor to the fixed-pattern Sequence_Detector.
- Matches a runtime-loadable PAT_W-bit pattern on a 1-bit input stream qualified by a valid strobe.
- Selectable overlapping or non-overlapping detection, with a saturating match counter.
- Sits between the serial front end and status logic; detector_out keeps the legacy single-pulse semantics.

Parameters:
PAT_W, 4, pattern length in bits (2..32)
DEFAULT_PAT, 4'b1011, pattern loaded at reset (PAT_W bits, MSB = oldest bit)
CNT_W, 8, match counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
sequence_in  input  1  serial data bit
in_valid  input  1  sequence_in sampled only when high
pattern  input  PAT_W  new pattern, MSB = first bit in time
pattern_load  input  1  latch pattern, restart detection
overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
count_clear  input  1  synchronous clear of match_count
detector_out  output  1  one-cycle match pulse, registered
match_count  output  CNT_W  saturating count of matches

Behaviour:
- Reset (reset low, asynchronous):
  - hist = 0, fill = 0, pat_reg = DEFAULT_PAT.
  - detector_out = 0, match_count = 0.
- History:
  - On each edge with in_valid=1: hist <= {hist[PAT_W-2:0], sequence_in}; fill <= min(fill+1, PAT_W).
  - fill width is clog2(PAT_W+1).
- Match condition, evaluated on the shifted-in value:
  - new_hist == pat_reg AND new fill == PAT_W.
  - Bits seen before reset, pattern_load or a non-overlap restart never contribute to a match.
- Latency: detector_out is high exactly the cycle after the edge that samples the final matching bit, then low again.
- Valid gating: in_valid=0 holds hist and fill. detector_out drops to 0 next cycle; no match can occur.
- Overlap handling on a match:
  - overlap_en=1: hist and fill keep updating normally, so a suffix of the match may seed the next one.
  - overlap_en=0: fill <= 0 on the match edge, so the next match needs PAT_W fresh bits.
  - overlap_en is sampled per edge and may change at any time.
- pattern_load=1:
  - pat_reg <= pattern; hist <= 0; fill <= 0.
  - Any in_valid bit on the same edge is discarded; no match on that edge.
- match_count:
  - Increments on each match edge; saturates at 2^CNT_W-1 (no wrap).
  - count_clear=1 forces 0 and takes priority over a simultaneous match increment.
  - detector_out still pulses when count_clear coincides with a match.
- Reset asserted mid-sequence: all state cleared immediately; a partial match is lost.
- Implementation: no combinational path from inputs to outputs.

Optional Feature:
Macro SEQ_DET_MASK_EN.
- Defined:
  - Extra input pattern_mask [PAT_W-1:0], latched with pattern_load; reset value is all-ones.
  - Match is ((new_hist ^ pat_reg) & mask_reg) == 0; mask bit 0 = don't-care.
  - fill rule still applies.
- Undefined: no port, exact compare, mask logic absent.

Decomposition:
- Package seq_det_pkg:
  - default constants SEQ_DET_PAT_W=4, SEQ_DET_DEFAULT_PAT=4'b1011, SEQ_DET_CNT_W=8.
  - function clog2 for the fill width.
- Sub-module seq_det_sat_counter:
  - parameter CNT_W; inputs clock, reset, inc, clr; output count.
  - clr-over-inc priority and saturation live here.
- Shift, compare and fill logic stay in the top module.

Test Plan:
- PAT_W=4, default 1011, overlap_en=1, stream 1,0,1,1,0,1,1 (in_valid=1) -> detector_out pulses one cycle after bits 4 and 7; match_count=2.
- Same stream with overlap_en=0 -> single pulse after bit 4; match_count=1.
- Bits 1,0,1, then reset low for 1 cycle, then bit 1 -> no pulse; all outputs 0 during and after reset.
- Bits 1,0 with in_valid=1, then 3 cycles in_valid=0 with sequence_in toggling, then 1,1 valid -> exactly one pulse after the final valid bit.
- pattern_load with pattern=0110 on the same edge as a valid bit, then stream 0,1,1,0 -> loaded bit ignored; pulse after the 4th bit; old pattern 1011 no longer matches.
- CNT_W=2, 5 non-overlapping matches -> match_count reaches 3 and holds. Then count_clear coincident with a 6th match -> detector_out pulses and match_count=0.
